core_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the existing datapath (pc, imem, control_unit, register_file, alu) through fetch/decode/execute/writeback instead of doing everything in one cycle. It issues a request/ready fetch handshake to instruction memory, gates PC update, instruction-register load and register-file write, and halts on ebreak or fetch timeout. It sits in top between the clock/reset and the datapath enables.

---
 rtl/core_sequencer_pkg.sv | 18 +
 rtl/core_sequencer_if.sv | 25 ++
 rtl/core_sequencer_timeout.sv | 35 +++
 rtl/core_sequencer.sv | 157 +++++++++++++++
 tb/tb_core_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the multi-cycle core sequencer (package core_seq_pkg).
// Optional perf counters elsewhere are enabled by CORE_SEQUENCER_PERF_CNT_EN.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_LD = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WB       = 3'd4,
        ST_HALT     = 3'd5,
        ST_ERROR    = 3'd6
    } seq_state_e;

    localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake and datapath-enable bundle between the sequencer (master) and the datapath/imem (slave).
interface core_sequencer_if;

    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr_in;
    logic        ir_we;
    logic        dec_reg_write;
    logic        is_ebreak;
    logic        rf_we;
    logic        pc_we;
    logic        pc_load_reset;
    logic [31:0] reset_pc;

    modport master (
        output imem_req, ir_we, rf_we, pc_we, pc_load_reset, reset_pc,
        input  imem_ready, instr_in, dec_reg_write, is_ebreak
    );

    modport slave (
        input  imem_req, ir_we, rf_we, pc_we, pc_load_reset, reset_pc,
        output imem_ready, instr_in, dec_reg_write, is_ebreak
    );

endinterface

// File: rtl/core_sequencer_timeout.sv
// Fetch wait counter: counts FETCH cycles without imem_ready, flags the last allowed one.
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control FSM gating the datapath enables.
// Define CORE_SEQUENCER_PERF_CNT_EN to add retired_cnt / cycle_cnt outputs.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    core_sequencer_if.master   bus,
    output logic               halted,
    output logic               fetch_err,
    output logic [2:0]         state_o
`ifdef CORE_SEQUENCER_PERF_CNT_EN
    ,
    output logic [31:0]        retired_cnt,
    output logic [31:0]        cycle_cnt
`endif
);

    seq_state_e state_d, state_q;
    logic       halted_d, halted_q;
    logic       fetch_err_d, fetch_err_q;
    logic       to_clear, to_en, to_expired;

    logic imem_req, ir_we, rf_we, pc_we, pc_load_reset;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .en      (to_en),
        .expired (to_expired)
    );

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        fetch_err_d   = fetch_err_q;
        to_clear      = 1'b1;
        to_en         = 1'b0;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        rf_we         = 1'b0;
        pc_we         = 1'b0;
        pc_load_reset = 1'b0;

        case (state_q)
            ST_RESET_LD: begin
                pc_load_reset = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                to_clear = 1'b0;
                if (bus.imem_ready) begin
                    ir_we    = 1'b1;
                    to_clear = 1'b1;
                    state_d  = ST_DECODE;
                end else if (to_expired) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_ERROR;
                end else begin
                    to_en = 1'b1;
                end
            end
            ST_DECODE: begin
                if (bus.is_ebreak) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we   = bus.dec_reg_write;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_RESET_LD;
            end
        endcase

        // Reset is synchronous, so the state register still shows the old state this cycle; mask its pulses.
        if (rst) begin
            imem_req      = 1'b0;
            ir_we         = 1'b0;
            rf_we         = 1'b0;
            pc_we         = 1'b0;
            pc_load_reset = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET_LD;
            halted_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            fetch_err_q <= fetch_err_d;
        end
    end

`ifdef CORE_SEQUENCER_PERF_CNT_EN
    logic [31:0] retired_d, retired_q;
    logic [31:0] cycle_d, cycle_q;

    always_comb begin
        retired_d = retired_q;
        cycle_d   = cycle_q;
        if (state_q == ST_WB) begin
            retired_d = retired_q + 32'd1;
        end
        if ((state_q == ST_FETCH) || (state_q == ST_DECODE) ||
            (state_q == ST_EXEC)  || (state_q == ST_WB)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
        end
    end

    assign retired_cnt = retired_q;
    assign cycle_cnt   = cycle_q;
`endif

    assign bus.imem_req      = imem_req;
    assign bus.ir_we         = ir_we;
    assign bus.rf_we         = rf_we;
    assign bus.pc_we         = pc_we;
    assign bus.pc_load_reset = pc_load_reset;
    assign bus.reset_pc      = RESET_PC;

    assign halted    = halted_q;
    assign fetch_err = fetch_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench: per-cycle expectation tables built from an instruction-level schedule model,
// plus a hand-written reset-during-EXEC sequence.
module tb_core_sequencer;
    import core_seq_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted, fetch_err;
    logic [2:0] state_o;
`ifdef CORE_SEQUENCER_PERF_CNT_EN
    logic [31:0] retired_cnt, cycle_cnt;
`endif

    core_sequencer_if bus ();

    core_sequencer #(
        .TIMEOUT_CYCLES (TO),
        .RESET_PC       (32'h8000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .halted    (halted),
        .fetch_err (fetch_err),
        .state_o   (state_o)
`ifdef CORE_SEQUENCER_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign bus.is_ebreak = (bus.instr_in == EBREAK_INSN);

    typedef struct packed {
        logic        ready;
        logic [31:0] instr;
        logic        rw;
        logic [2:0]  st;
        logic        req, ir, rf, pc, pcl, hlt, err;
        logic [31:0] ret, cyc;
    } vec_t;

    vec_t vec [0:127];
    int   nvec;
    int   n_applied = 0;
    int   n_mis     = 0;

    int          q_w  [$];
    bit          q_rw [$];
    bit          q_eb [$];
    logic [31:0] q_in [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic clear_prog();
        q_w.delete(); q_rw.delete(); q_eb.delete(); q_in.delete();
    endtask

    task automatic add_instr(input int w, input bit rw, input bit eb);
        q_w.push_back(w);
        q_rw.push_back(rw);
        q_eb.push_back(eb);
        q_in.push_back({$urandom} & 32'hFFFF_FF80 | 32'h13);
    endtask

    // Schedule model: each instruction costs (wait+1) fetch cycles, then DECODE, EXEC, WB.
    task automatic build(input int ncyc);
        int k, term, w, nf, s, r, y;
        nvec = ncyc;
        for (int c = 0; c < 128; c++) begin
            vec[c]       = '0;
            vec[c].ready = 1'($urandom_range(0, 1));
            vec[c].instr = 32'h0050_0093;
            vec[c].rw    = 1'($urandom_range(0, 1));
        end
        vec[0].pcl = 1'b1;
        k = 1;
        term = 0;
        for (int i = 0; i < q_w.size() && term == 0; i++) begin
            w  = q_w[i];
            nf = (w >= TO) ? TO : w + 1;
            s  = k;
            for (int j = 0; j < nf; j++) begin
                vec[k].st = 3'd1; vec[k].req = 1'b1;
                vec[k].ready = (j == w); vec[k].ir = (j == w);
                k++;
            end
            if (w >= TO) begin
                term = 2;
            end else begin
                vec[k].st = 3'd2; k++;
                if (q_eb[i]) begin
                    term = 1;
                end else begin
                    vec[k].st = 3'd3; k++;
                    vec[k].st = 3'd4; vec[k].rf = q_rw[i]; vec[k].pc = 1'b1; k++;
                end
            end
            for (int c = s; c < k; c++) begin
                vec[c].instr = q_eb[i] ? EBREAK_INSN : q_in[i];
                vec[c].rw    = q_rw[i];
            end
        end
        for (int c = k; c < 128; c++) vec[c].st = (term == 1) ? 3'd5 : 3'd6;
        r = 0; y = 0;
        for (int c = 0; c < 128; c++) begin
            vec[c].hlt = (vec[c].st == 3'd5);
            vec[c].err = (vec[c].st == 3'd6);
            vec[c].ret = r;
            vec[c].cyc = y;
            if (vec[c].st >= 3'd1 && vec[c].st <= 3'd4) y++;
            if (vec[c].st == 3'd4) r++;
        end
    endtask

    task automatic do_reset_and_check(input string nm);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk({nm, "_reset"},
            {22'd0, bus.imem_req, bus.ir_we, bus.rf_we, bus.pc_we, bus.pc_load_reset, halted, fetch_err, state_o},
            32'd0);
    endtask

    task automatic run_table(input string nm);
        do_reset_and_check(nm);
        rst = 1'b0;
        for (int c = 0; c < nvec; c++) begin
            if (c > 0) @(negedge clk);
            bus.imem_ready    = vec[c].ready;
            bus.instr_in      = vec[c].instr;
            bus.dec_reg_write = vec[c].rw;
            #1;
            chk($sformatf("%s_cyc%0d", nm, c),
                {22'd0, bus.imem_req, bus.ir_we, bus.rf_we, bus.pc_we, bus.pc_load_reset, halted, fetch_err, state_o},
                {22'd0, vec[c].req, vec[c].ir, vec[c].rf, vec[c].pc, vec[c].pcl, vec[c].hlt, vec[c].err, vec[c].st});
`ifdef CORE_SEQUENCER_PERF_CNT_EN
            chk($sformatf("%s_retired%0d", nm, c), retired_cnt, vec[c].ret);
            chk($sformatf("%s_cycles%0d", nm, c), cycle_cnt, vec[c].cyc);
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ready    = 1'b0;
        bus.instr_in      = 32'h0050_0093;
        bus.dec_reg_write = 1'b0;

        clear_prog(); add_instr(0, 1, 0); add_instr(0, 0, 1);
        build(14); run_table("addi_ebreak");
        chk("reset_pc", bus.reset_pc, 32'h8000_0000);

        clear_prog(); add_instr(3, 1, 0); add_instr(0, 0, 1);
        build(16); run_table("wait3");

        clear_prog(); add_instr(10, 1, 0);
        build(10); run_table("timeout");

        clear_prog(); add_instr(4, 1, 0);
        build(9); run_table("timeout_edge");

        clear_prog(); add_instr(0, 0, 0); add_instr(1, 1, 0); add_instr(0, 0, 1);
        build(16); run_table("store");

        clear_prog(); add_instr(0, 1, 0); add_instr(0, 1, 0); add_instr(0, 0, 0); add_instr(0, 0, 1);
        build(18); run_table("three_instr");

        for (int t = 0; t < 4; t++) begin
            clear_prog();
            for (int i = 0; i < 6; i++)
                add_instr($urandom_range(0, 5), 1'($urandom_range(0, 1)),
                          (i == 5) || ($urandom_range(0, 7) == 0));
            build(56); run_table($sformatf("rand%0d", t));
        end

        // Reset asserted during EXEC abandons the instruction and restarts from the reset vector.
        do_reset_and_check("mid_exec");
        rst = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.instr_in      = 32'h0050_0093;
        bus.dec_reg_write = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        chk("mid_exec_state", {29'd0, state_o}, 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_exec_nopulse", {30'd0, bus.rf_we, bus.pc_we}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_exec_after", {27'd0, bus.rf_we, bus.pc_we, state_o}, 32'd0);
        chk("mid_exec_pcl_held", {31'd0, bus.pc_load_reset}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_exec_pcl", {28'd0, bus.pc_load_reset, state_o}, {28'd0, 1'b1, 3'd0});
        @(negedge clk);
        #1;
        chk("mid_exec_refetch", {27'd0, bus.imem_req, bus.ir_we, state_o}, {27'd0, 1'b1, 1'b1, 3'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
        $finish;
    end

endmodule
